calc_cmd_sched: RTL and testbench
=================================

# calc_cmd_sched

Command scheduler in front of the calculator core. Shares the core's single 4-bit command input between two requesters: keypad and host. Each requester has a valid/ready handshake and its own small FIFO. Commands are issued only when the core's `status` allows, and one requester's expression is never interleaved with the other's.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: entries per requester FIFO; power of two, ≥2.
- `TIMEOUT`, default 1024: maximum cycles to wait for the core to leave OCUPADA.
- `WAIT_LAT`, default 2: cycles to wait for the core to leave PRONTA after `=`.

Ports (reset is `reset`, synchronous, active-high; clock is `clock`):
- `clock`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `kp_cmd`, in, 4: keypad command code.
- `kp_valid`, in, 1: keypad command present.
- `kp_ready`, out, 1: keypad FIFO not full.
- `host_cmd`, in, 4: host command code.
- `host_valid`, in, 1: host command present.
- `host_ready`, out, 1: host FIFO not full.
- `calc_status`, in, 2: core state. 0 = ERRO, 1 = PRONTA, 2 = OCUPADA.
- `calc_cmd`, out, 4: command to the core.
- `calc_cmd_valid`, out, 1: one-cycle strobe; the core samples `calc_cmd` only while this is high.
- `owner`, out, 2: lock holder. 00 = none, 01 = keypad, 10 = host.
- `busy`, out, 1: high in any state other than IDLE.
- `drop`, out, 1: one-cycle pulse when a popped command is discarded.
- `timeout`, out, 1: one-cycle pulse when the OCUPADA wait expires.

## Operation
Command codes: digits 0–9; 1010 `+`; 1011 `-`; 1100 `×`; 1110 `=`; 1111 backspace/clear.

Requester FIFOs:
- A push happens when `valid && ready`.
- `ready` equals "FIFO not full", registered.

States:
- **IDLE**
  - When `owner` is none, pick a non-empty FIFO. If both are non-empty, round-robin; after reset the keypad has priority.
  - When `owner` is set, consider only the owner's FIFO. The other FIFO keeps buffering.
  - On a pick, pop the head.
- **ISSUE** (1 cycle)
  - `calc_status` = PRONTA: drive `calc_cmd` and `calc_cmd_valid` = 1.
    - If `owner` is none, set it to the picked requester.
  - `calc_status` = ERRO: only 1111 is forwarded. Any other code is discarded and `drop` pulses.
  - `calc_status` = OCUPADA: discard the command and pulse `drop` (the core should not be busy while in this state).
- **SETTLE** (1 cycle): lets the core's status update.
  - Go to WAIT_BUSY if the issued command was `=`.
  - Release the lock and go to IDLE if status = ERRO, or if the issued command was 1111 in ERRO.
  - Otherwise go to IDLE.
- **WAIT_BUSY**
  - Status ≠ PRONTA → WAIT_DONE.
  - Status still PRONTA after `WAIT_LAT` cycles → release the lock, go to IDLE. This covers `=` with no pending work.
- **WAIT_DONE**
  - Status = PRONTA or ERRO → release the lock, go to IDLE.
  - Counter reaches `TIMEOUT` → pulse `timeout`, release the lock, go to IDLE.

Lock:
- Acquired on the first forwarded command.
- Released only through the `=`/error/clear/timeout paths above.

## Timing
- Reset values: `calc_cmd` = 0, `calc_cmd_valid` = 0, `owner` = 00, `busy` = 0, `drop` = 0, `timeout` = 0, `kp_ready` = 1, `host_ready` = 1.
- Reset clears both FIFOs, the round-robin pointer, and the counters. Reset mid-transaction aborts it; nothing is issued on the cycle after reset.
- Latency: a push into an empty FIFO with state IDLE gives `calc_cmd_valid` 2 cycles later (IDLE pick, then ISSUE).
- Throughput: at most one command every 3 cycles (IDLE, ISSUE, SETTLE).
- Push and pop on the same FIFO in the same cycle is allowed, including when the FIFO is full (ready stays low that cycle).
- Pointers wrap modulo `FIFO_DEPTH`. The occupancy counter is `$clog2(FIFO_DEPTH)+1` bits wide.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide, is cleared on entry to WAIT_DONE, and saturates.

## Structure
- Package `calc_pkg`:
  - status enum (ERRO, PRONTA, OCUPADA);
  - command code localparams (`CMD_ADD`, `CMD_SUB`, `CMD_MUL`, `CMD_EQ`, `CMD_CLR`);
  - owner encodings.
  - The calculator core is to adopt the same package.
- Sub-module `cmd_fifo`: synchronous FIFO (4-bit data, `FIFO_DEPTH`, `full`/`empty`), instantiated twice.
- Scheduler FSM and arbiter live in `calc_cmd_sched`.

## Test plan
1. Keypad pushes 1, 2, `+`, 3, `=`; status model PRONTA → OCUPADA for 8 cycles → PRONTA. Required: `calc_cmd` sequence 1, 2, 1010, 3, 1110, spaced 3 cycles apart; `owner` = 01 until status returns PRONTA, then 00.
2. Host pushes 7, `×`, 4, `=` while keypad is locked mid-expression. Required: no host command is issued until the keypad's `=` completes; the host's FIFO holds 4 entries and `host_ready` drops when it is full.
3. Both requesters push on the same cycle from reset. Required: keypad is granted first. On the next contention after both locks are released, host is granted.
4. Status forced to ERRO; keypad pushes 5, then 1111. Required: `drop` pulses for the 5; 1111 is issued; the lock is released.
5. `=` issued and status held at OCUPADA. Required: `timeout` pulses exactly `TIMEOUT` cycles after WAIT_DONE entry; `owner` = 00 next cycle.
6. Reset asserted during WAIT_DONE with both FIFOs non-empty. Required: all outputs take their reset values the next cycle; FIFOs are empty; no `calc_cmd_valid`.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator core and its command scheduler:
// core status, command codes and lock-owner values.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_ERRO    = 2'd0,
        ST_PRONTA  = 2'd1,
        ST_OCUPADA = 2'd2
    } calc_status_e;

    localparam logic [3:0] CMD_ADD = 4'b1010;
    localparam logic [3:0] CMD_SUB = 4'b1011;
    localparam logic [3:0] CMD_MUL = 4'b1100;
    localparam logic [3:0] CMD_EQ  = 4'b1110;
    localparam logic [3:0] CMD_CLR = 4'b1111;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_KP   = 2'b01,
        OWN_HOST = 2'b10
    } owner_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous 4-bit command FIFO; head is visible combinationally, pop takes effect at the edge.
// Pushes while full are ignored; full/empty are registered so ready never depends on same-cycle pop.
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [3:0] push_data,
    input  logic       pop,
    output logic [3:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            full  <= (count_n == FULL_CNT);
            empty <= (count_n == '0);
        end
    end

endmodule

// File: rtl/calc_cmd_sched.sv
// Arbitrates keypad/host command FIFOs onto the core's single command port, locking one expression at a time.
// Push-to-strobe latency 2 cycles, one command per 3 cycles; requesters are backpressured only by FIFO full.
module calc_cmd_sched
    import calc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024,
    parameter int WAIT_LAT   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] kp_cmd,
    input  logic       kp_valid,
    output logic       kp_ready,
    input  logic [3:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [1:0] calc_status,
    output logic [3:0] calc_cmd,
    output logic       calc_cmd_valid,
    output logic [1:0] owner,
    output logic       busy,
    output logic       drop,
    output logic       timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int WW = $clog2(WAIT_LAT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WL_LAST = WW'(WAIT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_SETTLE, S_WAIT_BUSY, S_WAIT_DONE
    } state_e;

    state_e        state;
    logic          kp_full, kp_empty, host_full, host_empty;
    logic [3:0]    kp_head, host_head, cur_cmd;
    logic          pick_kp, pick_host;
    logic          rr_host, cur_host, fwd, err_issue;
    logic [TW-1:0] tcnt;
    logic [WW-1:0] wcnt;

    assign kp_ready   = !kp_full;
    assign host_ready = !host_full;

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_kp_fifo (
        .clock(clock), .reset(reset), .push(kp_valid), .push_data(kp_cmd),
        .pop(pick_kp), .head(kp_head), .full(kp_full), .empty(kp_empty)
    );

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_host_fifo (
        .clock(clock), .reset(reset), .push(host_valid), .push_data(host_cmd),
        .pop(pick_host), .head(host_head), .full(host_full), .empty(host_empty)
    );

    // A held lock restricts the pick to the owner; otherwise contention is settled by rr_host.
    always_comb begin
        pick_kp   = 1'b0;
        pick_host = 1'b0;
        if (state == S_IDLE) begin
            case (owner)
                OWN_KP:   pick_kp   = !kp_empty;
                OWN_HOST: pick_host = !host_empty;
                default: begin
                    if (!kp_empty && !host_empty) begin
                        pick_host = rr_host;
                        pick_kp   = !rr_host;
                    end else begin
                        pick_kp   = !kp_empty;
                        pick_host = !host_empty;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            owner          <= OWN_NONE;
            rr_host        <= 1'b0;
            cur_cmd        <= '0;
            cur_host       <= 1'b0;
            fwd            <= 1'b0;
            err_issue      <= 1'b0;
            calc_cmd       <= '0;
            calc_cmd_valid <= 1'b0;
            busy           <= 1'b0;
            drop           <= 1'b0;
            timeout        <= 1'b0;
            wcnt           <= '0;
            tcnt           <= '0;
        end else begin
            calc_cmd_valid <= 1'b0;
            drop           <= 1'b0;
            timeout        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_kp || pick_host) begin
                        cur_cmd  <= pick_host ? host_head : kp_head;
                        cur_host <= pick_host;
                        // Pointer only moves on real contention so a lone requester does not steal the next turn.
                        if (owner == OWN_NONE && !kp_empty && !host_empty) rr_host <= pick_kp;
                        state    <= S_ISSUE;
                        busy     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state     <= S_SETTLE;
                    err_issue <= (calc_status == ST_ERRO);
                    if (calc_status == ST_PRONTA ||
                        (calc_status == ST_ERRO && cur_cmd == CMD_CLR)) begin
                        calc_cmd       <= cur_cmd;
                        calc_cmd_valid <= 1'b1;
                        fwd            <= 1'b1;
                        if (owner == OWN_NONE) owner <= cur_host ? OWN_HOST : OWN_KP;
                    end else begin
                        drop <= 1'b1;
                        fwd  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (fwd && cur_cmd == CMD_EQ) begin
                        state <= S_WAIT_BUSY;
                        wcnt  <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (calc_status == ST_ERRO || (fwd && err_issue)) owner <= OWN_NONE;
                    end
                end
                S_WAIT_BUSY: begin
                    if (calc_status != ST_PRONTA) begin
                        state <= S_WAIT_DONE;
                        tcnt  <= '0;
                    end else if (wcnt == WL_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        owner <= OWN_NONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (calc_status == ST_PRONTA || calc_status == ST_ERRO) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        owner <= OWN_NONE;
                    end else if (tcnt == TO_LAST) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        owner   <= OWN_NONE;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_cmd_sched.sv
// Directed bench for calc_cmd_sched: arbitration, locking, error handling, timeout and reset abort.
module tb_calc_cmd_sched;
    import calc_pkg::*;

    localparam int TO = 20;

    logic       clock;
    logic       reset;
    logic [3:0] kp_cmd, host_cmd, calc_cmd;
    logic       kp_valid, kp_ready, host_valid, host_ready;
    logic [1:0] calc_status, owner;
    logic       calc_cmd_valid, busy, drop, timeout;

    calc_cmd_sched #(.FIFO_DEPTH(4), .TIMEOUT(TO), .WAIT_LAT(2)) dut (
        .clock(clock), .reset(reset),
        .kp_cmd(kp_cmd), .kp_valid(kp_valid), .kp_ready(kp_ready),
        .host_cmd(host_cmd), .host_valid(host_valid), .host_ready(host_ready),
        .calc_status(calc_status), .calc_cmd(calc_cmd), .calc_cmd_valid(calc_cmd_valid),
        .owner(owner), .busy(busy), .drop(drop), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nchk = 0;
    int nbad = 0;
    int cyc = 0;
    int q_cmd[$];
    int q_own[$];
    int q_cyc[$];
    int drops = 0;
    int touts = 0;
    int tout_cyc = 0;

    // Observes the DUT shortly after each rising edge; the stimulus side reads these at the falling edge.
    always @(posedge clock) begin
        #2;
        cyc++;
        if (calc_cmd_valid) begin
            q_cmd.push_back(int'(calc_cmd));
            q_own.push_back(int'(owner));
            q_cyc.push_back(cyc);
        end
        if (drop) drops++;
        if (timeout) begin
            touts++;
            tout_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_iss(input string tag, input int idx, input int cmd, input int own);
        if (idx < q_cmd.size()) begin
            check({tag, "_cmd"}, q_cmd[idx], cmd);
            check({tag, "_own"}, q_own[idx], own);
        end else begin
            check({tag, "_missing"}, q_cmd.size(), idx + 1);
        end
    endtask

    task automatic wait_issue(input string tag, input int n, input int bound);
        int k = 0;
        while (q_cmd.size() < n && k < bound) begin
            @(negedge clock);
            k++;
        end
        if (q_cmd.size() < n) check(tag, q_cmd.size(), n);
    endtask

    task automatic push_kp(input logic [3:0] c);
        int k = 0;
        kp_cmd   = c;
        kp_valid = 1'b1;
        while (!kp_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!kp_ready) check("kp_push_stall", 0, 1);
        @(negedge clock);
        kp_valid = 1'b0;
    endtask

    task automatic push_host(input logic [3:0] c);
        int k = 0;
        host_cmd   = c;
        host_valid = 1'b1;
        while (!host_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!host_ready) check("host_push_stall", 0, 1);
        @(negedge clock);
        host_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd"}, calc_cmd, 0);
        check({tag, "_vld"}, calc_cmd_valid, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_drop"}, drop, 0);
        check({tag, "_tout"}, timeout, 0);
        check({tag, "_kp_rdy"}, kp_ready, 1);
        check({tag, "_host_rdy"}, host_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, d0, t0, ec, k;
        int exp1[5];
        int exp2c[8];
        int exp2o[8];
        int exp3c[8];
        int exp3o[8];

        kp_valid = 0; host_valid = 0; kp_cmd = 0; host_cmd = 0;
        calc_status = 2'd1;
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b0;

        // 1: keypad expression 1 2 + 3 =, core busy 8 cycles after '='
        exp1 = '{1, 2, 10, 3, 14};
        base = q_cmd.size();
        push_kp(4'd1); push_kp(4'd2); push_kp(CMD_ADD); push_kp(4'd3); push_kp(CMD_EQ);
        wait_issue("t1_wait", base + 5, 60);
        calc_status = 2'd2;
        repeat (8) @(negedge clock);
        check("t1_own_locked", owner, 1);
        calc_status = 2'd1;
        @(negedge clock);
        check("t1_own_released", owner, 0);
        check("t1_busy_idle", busy, 0);
        for (int i = 0; i < 5; i++) check_iss($sformatf("t1_i%0d", i), base + i, exp1[i], 1);
        for (int i = 1; i < 5; i++)
            if (base + i < q_cyc.size())
                check($sformatf("t1_gap%0d", i), q_cyc[base + i] - q_cyc[base + i - 1], 3);

        // 2: host fills its FIFO while keypad holds the lock
        exp2c = '{8, 10, 2, 14, 7, 12, 4, 14};
        exp2o = '{1, 1, 1, 1, 2, 2, 2, 2};
        base = q_cmd.size();
        push_kp(4'd8); push_kp(CMD_ADD);
        wait_issue("t2_wait_a", base + 2, 40);
        push_host(4'd7); push_host(CMD_MUL); push_host(4'd4); push_host(CMD_EQ);
        check("t2_host_full", host_ready, 0);
        repeat (5) @(negedge clock);
        check("t2_no_host_yet", q_cmd.size(), base + 2);
        push_kp(4'd2); push_kp(CMD_EQ);
        wait_issue("t2_wait_b", base + 4, 40);
        calc_status = 2'd2;
        repeat (3) @(negedge clock);
        check("t2_no_host_in_wait", q_cmd.size(), base + 4);
        calc_status = 2'd1;
        wait_issue("t2_wait_c", base + 8, 60);
        repeat (5) @(negedge clock);
        check("t2_own_released", owner, 0);
        check("t2_host_rdy_back", host_ready, 1);
        for (int i = 0; i < 8; i++) check_iss($sformatf("t2_i%0d", i), base + i, exp2c[i], exp2o[i]);

        // 3: simultaneous pushes from reset; second contention goes to host
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp3c = '{1, 14, 2, 14, 4, 14, 3, 14};
        exp3o = '{1, 1, 2, 2, 2, 2, 1, 1};
        base = q_cmd.size();
        kp_cmd = 4'd1; host_cmd = 4'd2; kp_valid = 1; host_valid = 1;
        @(negedge clock);
        kp_cmd = CMD_EQ; host_cmd = CMD_EQ;
        @(negedge clock);
        kp_valid = 0; host_valid = 0;
        wait_issue("t3_wait_a", base + 4, 60);
        repeat (6) @(negedge clock);
        check("t3_own_mid", owner, 0);
        kp_cmd = 4'd3; host_cmd = 4'd4; kp_valid = 1; host_valid = 1;
        @(negedge clock);
        kp_cmd = CMD_EQ; host_cmd = CMD_EQ;
        @(negedge clock);
        kp_valid = 0; host_valid = 0;
        wait_issue("t3_wait_b", base + 8, 60);
        repeat (6) @(negedge clock);
        for (int i = 0; i < 8; i++) check_iss($sformatf("t3_i%0d", i), base + i, exp3c[i], exp3o[i]);

        // 4: core in ERRO, only clear is forwarded
        calc_status = 2'd0;
        base = q_cmd.size();
        d0 = drops;
        push_kp(4'd5); push_kp(CMD_CLR);
        wait_issue("t4_wait", base + 1, 40);
        repeat (3) @(negedge clock);
        check("t4_drops", drops - d0, 1);
        check("t4_n_issued", q_cmd.size() - base, 1);
        check_iss("t4_clr", base, 15, 1);
        check("t4_own_released", owner, 0);
        calc_status = 2'd1;
        @(negedge clock);

        // 5: '=' then core stuck busy
        base = q_cmd.size();
        push_kp(CMD_EQ);
        wait_issue("t5_wait", base + 1, 40);
        ec = (base < q_cyc.size()) ? q_cyc[base] : 0;
        calc_status = 2'd2;
        t0 = touts;
        repeat (5) @(negedge clock);
        check("t5_own_locked", owner, 1);
        k = 0;
        while (touts == t0 && k < 80) begin
            @(negedge clock);
            k++;
        end
        check("t5_tout_seen", touts - t0, 1);
        check("t5_tout_cycle", tout_cyc - ec, TO + 2);
        @(negedge clock);
        check("t5_tout_single", touts - t0, 1);
        check("t5_own_released", owner, 0);
        check("t5_busy_idle", busy, 0);
        calc_status = 2'd1;
        @(negedge clock);

        // 6: reset while waiting on the core with both FIFOs holding commands
        base = q_cmd.size();
        push_kp(CMD_EQ);
        wait_issue("t6_wait", base + 1, 40);
        calc_status = 2'd2;
        push_host(4'd3);
        push_kp(4'd4);
        repeat (2) @(negedge clock);
        check("t6_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("t6_rst");
        reset = 1'b0;
        calc_status = 2'd1;
        n = q_cmd.size();
        repeat (10) @(negedge clock);
        check("t6_no_issue", q_cmd.size(), n);
        check("t6_busy_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
